// File: rtl/fpu_issue_ctrl_pkg.sv
// Opcode encoding, controller state type and helpers shared by the
// FP issue controller, its latency table and its bus interface.
package fpu_ctrl_pkg;

    localparam int OP_W = 5;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD  = 5'd0;
    localparam op_t OP_SUB  = 5'd1;
    localparam op_t OP_MUL  = 5'd2;
    localparam op_t OP_DIV  = 5'd3;
    localparam op_t OP_SQRT = 5'd4;
    localparam op_t OP_MIN  = 5'd5;
    localparam op_t OP_MAX  = 5'd6;
    localparam op_t OP_LT   = 5'd7;
    localparam op_t OP_EQ   = 5'd8;
    localparam op_t OP_LE   = 5'd9;
    localparam op_t OP_CONV = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic op_legal(input op_t op);
        return op <= OP_CONV;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response handshake bundle between the register-file read
// stage (master) and the FP issue controller (slave).
interface fpu_issue_if
#(
    parameter int TAG_W = 4
);
    import fpu_ctrl_pkg::*;

    logic             req_valid;
    logic             req_ready;
    op_t              req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_illegal;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_illegal
    );

endinterface

// File: rtl/fpu_issue_ctrl_lat_lookup.sv
// Combinational opcode decode: legality and fixed ALU latency in cycles
// from operand drive to a valid result.
module fpu_lat_lookup
    import fpu_ctrl_pkg::*;
#(
    parameter int DIV_LAT  = 8,
    parameter int SQRT_LAT = 12,
    parameter int COMB_LAT = 1,
    parameter int CNT_W    = 5
) (
    input  op_t              op,
    output logic             legal,
    output logic [CNT_W-1:0] lat
);

    logic is_div;
    logic is_sqrt;
    logic is_comb;

    assign is_div  = (op == OP_DIV);
    assign is_sqrt = (op == OP_SQRT);
    assign is_comb = op_legal(op) && !is_div && !is_sqrt;

    always_comb begin
        legal = 1'b0;
        lat   = '0;
        unique case (1'b1)
            is_div: begin
                legal = 1'b1;
                lat   = CNT_W'(DIV_LAT);
            end
            is_sqrt: begin
                legal = 1'b1;
                lat   = CNT_W'(SQRT_LAT);
            end
            is_comb: begin
                legal = 1'b1;
                lat   = CNT_W'(COMB_LAT);
            end
            default: begin
                legal = 1'b0;
                lat   = '0;
            end
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-issue sequencer for the FP ALU: holds operands for the op's
// fixed latency, captures the result and returns it with its tag.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int TAG_W    = 4,
    parameter int DIV_LAT  = 8,
    parameter int SQRT_LAT = 12,
    parameter int COMB_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    fpu_issue_if.slave  bus,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output op_t         alu_op,
    input  logic [31:0] alu_result,
    output logic        busy
);

    localparam int MAX_LAT = max3(DIV_LAT, SQRT_LAT, COMB_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [31:0]      a_n;
    logic [31:0]      b_n;
    op_t              op_n;
    logic [31:0]      data_q;
    logic [31:0]      data_n;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_n;
    logic             ill_q;
    logic             ill_n;
    logic             legal;
    logic [CNT_W-1:0] lat;
    logic             accept;

    fpu_lat_lookup #(
        .DIV_LAT  (DIV_LAT),
        .SQRT_LAT (SQRT_LAT),
        .COMB_LAT (COMB_LAT),
        .CNT_W    (CNT_W)
    ) u_lat (
        .op    (bus.req_op),
        .legal (legal),
        .lat   (lat)
    );

    // A consumed response frees the slot in the same cycle.
    assign bus.req_ready = (state == ST_IDLE) ||
                           (state == ST_RESP && bus.rsp_ready);
    assign accept          = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid   = (state == ST_RESP);
    assign bus.rsp_data    = data_q;
    assign bus.rsp_tag     = tag_q;
    assign bus.rsp_illegal = ill_q;
    assign busy            = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = alu_a;
        b_n     = alu_b;
        op_n    = alu_op;
        data_n  = data_q;
        tag_n   = tag_q;
        ill_n   = ill_q;
        unique case (state)
            ST_EXEC: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    data_n  = alu_result;
                    ill_n   = 1'b0;
                    state_n = ST_RESP;
                end
            end
            default: begin
                if (state == ST_RESP && bus.rsp_ready) begin
                    state_n = ST_IDLE;
                end
                if (accept) begin
                    a_n   = bus.req_a;
                    b_n   = bus.req_b;
                    op_n  = bus.req_op;
                    tag_n = bus.req_tag;
                    if (legal) begin
                        cnt_n   = lat - CNT_W'(1);
                        state_n = ST_EXEC;
                    end else begin
                        // Illegal ops never touch the ALU result.
                        data_n  = '0;
                        ill_n   = 1'b1;
                        state_n = ST_RESP;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            data_q <= '0;
            tag_q  <= '0;
            ill_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            alu_a  <= a_n;
            alu_b  <= b_n;
            alu_op <= op_n;
            data_q <= data_n;
            tag_q  <= tag_n;
            ill_q  <= ill_n;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a latency-aware ALU stand-in
// that only yields the true result once operands have been held long enough.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    fpu_issue_if #(.TAG_W(4)) bus ();

    fpu_issue_ctrl #(
        .TAG_W    (4),
        .DIV_LAT  (8),
        .SQRT_LAT (12),
        .COMB_LAT (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(logic [4:0] op, logic [31:0] a,
                                           logic [31:0] b);
        if (op == 5'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000)
            return 32'h4040_0000;
        if (op == 5'd3 && a == 32'h40C0_0000 && b == 32'h4000_0000)
            return 32'h4040_0000;
        return (a ^ {b[30:0], b[31]}) + {27'd0, op};
    endfunction

    function automatic int tb_lat(logic [4:0] op);
        if (op == 5'd3) return 8;
        if (op == 5'd4) return 12;
        return 1;
    endfunction

    int          age = 0;
    logic [68:0] last_in = '1;

    always @(posedge clk) begin
        #1;
        if ({alu_op, alu_a, alu_b} !== last_in) begin
            last_in = {alu_op, alu_a, alu_b};
            age = 1;
        end else begin
            age++;
        end
    end

    assign alu_result = (age >= tb_lat(alu_op)) ?
                        alu_fn(alu_op, alu_a, alu_b) : 32'hDEAD_BEEF;

    function automatic exp_t pop_exp();
        exp_t e;
        e.tag = 4'hF;
        e.data = 32'hFFFF_FFFF;
        e.ill = 1'bx;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic drive_req(input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] tag);
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_tag = tag;
    endtask

    task automatic push_exp(input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] tag);
        exp_t e;
        e.tag = tag;
        e.ill = (op > 5'd10);
        e.data = e.ill ? 32'd0 : alu_fn(op, a, b);
        sb.push_back(e);
    endtask

    task automatic wait_rsp(output int k);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, busy, bus.rsp_illegal} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.rsp_valid, busy, bus.rsp_illegal});
        end
        n_checks++;
        if ({alu_a, alu_b, alu_op, bus.rsp_data, bus.rsp_tag} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs a=%h b=%h op=%h d=%h t=%h want 0",
                     alu_a, alu_b, alu_op, bus.rsp_data, bus.rsp_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_add();
        int   k;
        exp_t e;
        bus.rsp_ready = 1'b1;
        drive_req(5'd0, 32'h3F80_0000, 32'h4000_0000, 4'h3);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_ready got %b want 1", bus.req_ready);
        end
        push_exp(5'd0, 32'h3F80_0000, 32'h4000_0000, 4'h3);
        wait_rsp(k);
        n_checks++;
        if (k != 2) begin
            n_fail++;
            $display("FAIL add_latency got %0d want 2", k);
        end
        e = pop_exp();
        n_checks++;
        if ({bus.rsp_data, bus.rsp_tag, bus.rsp_illegal} !==
            {32'h4040_0000, e.tag, 1'b0}) begin
            n_fail++;
            $display("FAIL add_rsp got %h/%h/%b want 40400000/%h/0",
                     bus.rsp_data, bus.rsp_tag, bus.rsp_illegal, e.tag);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL add_idle got %b want 00", {bus.rsp_valid, busy});
        end
    endtask

    task automatic test_div();
        exp_t e;
        bus.rsp_ready = 1'b1;
        drive_req(5'd3, 32'h40C0_0000, 32'h4000_0000, 4'h5);
        push_exp(5'd3, 32'h40C0_0000, 32'h4000_0000, 4'h5);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (alu_a !== 32'h40C0_0000 || alu_b !== 32'h4000_0000 ||
                alu_op !== 5'd3 || bus.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL div_hold c%0d a=%h b=%h op=%h v=%b",
                         i, alu_a, alu_b, alu_op, bus.rsp_valid);
            end
        end
        @(negedge clk);
        e = pop_exp();
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag} !==
            {1'b1, e.data, e.tag}) begin
            n_fail++;
            $display("FAIL div_rsp got %b/%h/%h want 1/%h/%h",
                     bus.rsp_valid, bus.rsp_data, bus.rsp_tag,
                     e.data, e.tag);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int   k;
        exp_t e;
        bus.rsp_ready = 1'b0;
        drive_req(5'd0, 32'h1234_5678, 32'h0F0F_0F0F, 4'h6);
        push_exp(5'd0, 32'h1234_5678, 32'h0F0F_0F0F, 4'h6);
        wait_rsp(k);
        n_checks++;
        if (k != 2) begin
            n_fail++;
            $display("FAIL bp_latency got %0d want 2", k);
        end
        drive_req(5'd2, 32'h1111_1111, 32'h2222_2222, 4'h7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_data, bus.rsp_tag} !==
                {2'b10, sb[0].data, sb[0].tag}) begin
                n_fail++;
                $display("FAIL bp_hold c%0d v=%b rdy=%b d=%h t=%h",
                         i, bus.rsp_valid, bus.req_ready,
                         bus.rsp_data, bus.rsp_tag);
            end
        end
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_passthru got %b want 1", bus.req_ready);
        end
        e = pop_exp();
        n_checks++;
        if ({bus.rsp_data, bus.rsp_tag} !== {e.data, e.tag}) begin
            n_fail++;
            $display("FAIL bp_rsp got %h/%h want %h/%h",
                     bus.rsp_data, bus.rsp_tag, e.data, e.tag);
        end
        push_exp(5'd2, 32'h1111_1111, 32'h2222_2222, 4'h7);
        wait_rsp(k);
        n_checks++;
        if (k != 2) begin
            n_fail++;
            $display("FAIL bp_mul_latency got %0d want 2", k);
        end
        e = pop_exp();
        n_checks++;
        if ({bus.rsp_data, bus.rsp_tag, bus.rsp_illegal} !==
            {e.data, e.tag, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_mul_rsp got %h/%h/%b want %h/%h/0",
                     bus.rsp_data, bus.rsp_tag, bus.rsp_illegal,
                     e.data, e.tag);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        int   k;
        exp_t e;
        bus.rsp_ready = 1'b1;
        drive_req(5'd20, 32'hAAAA_5555, 32'h5555_AAAA, 4'hA);
        push_exp(5'd20, 32'hAAAA_5555, 32'h5555_AAAA, 4'hA);
        wait_rsp(k);
        n_checks++;
        if (k != 1) begin
            n_fail++;
            $display("FAIL illegal_latency got %0d want 1", k);
        end
        e = pop_exp();
        n_checks++;
        if ({bus.rsp_illegal, bus.rsp_data, bus.rsp_tag} !==
            {e.ill, e.data, e.tag}) begin
            n_fail++;
            $display("FAIL illegal_rsp got %b/%h/%h want %b/%h/%h",
                     bus.rsp_illegal, bus.rsp_data, bus.rsp_tag,
                     e.ill, e.data, e.tag);
        end
        n_checks++;
        if (alu_op !== 5'd20) begin
            n_fail++;
            $display("FAIL illegal_op_latch got %0d want 20", alu_op);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sqrt();
        int extra = 0;
        bus.rsp_ready = 1'b1;
        drive_req(5'd4, 32'h4080_0000, 32'h0000_0000, 4'h9);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, busy, alu_a, alu_b, alu_op, bus.rsp_data,
             bus.rsp_tag, bus.rsp_illegal} !== '0) begin
            n_fail++;
            $display("FAIL sqrt_reset v=%b busy=%b a=%h op=%h t=%h",
                     bus.rsp_valid, busy, alu_a, alu_op, bus.rsp_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL sqrt_release got %b want 10",
                     {bus.req_ready, busy});
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL sqrt_no_rsp got %0d responses want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          got = 0;
        int          last_cyc = -1;
        exp_t        e;
        logic [31:0] a;
        logic [31:0] b;
        bus.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                e = pop_exp();
                n_checks++;
                if ({bus.rsp_data, bus.rsp_tag} !== {e.data, e.tag}) begin
                    n_fail++;
                    $display("FAIL b2b_rsp%0d got %h/%h want %h/%h", got,
                             bus.rsp_data, bus.rsp_tag, e.data, e.tag);
                end
                if (got > 0) begin
                    n_checks++;
                    if (cyc - last_cyc != 2) begin
                        n_fail++;
                        $display("FAIL b2b_gap%0d got %0d want 2",
                                 got, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            if (sent < 10) begin
                a = 32'h3F00_0000 + 32'(sent);
                b = 32'h0001_0001 * 32'(sent + 1);
                drive_req(5'd0, a, b, 4'(sent));
                if (bus.req_ready) begin
                    push_exp(5'd0, a, b, 4'(sent));
                    sent++;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        n_checks++;
        if (got != 10 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count got %0d left %0d want 10/0",
                     got, sb.size());
        end
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_tag = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_div();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_reset_mid_sqrt();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
